spi_oled_btn_master: RTL and testbench

//  FPGA-side SPI initiator (mode 0, MSB first) for the OLED/button bus: the bus that the ESP32 drives when the passthru core is loaded.

---
 rtl/spi_oled_btn_master.sv | 143 ++++++++++++++
 tb/tb_spi_oled_btn_master.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_oled_btn_master.sv
// SPI initiator (mode 0, MSB first) for the shared OLED/button bus.
// Each byte is sent on MOSI while the bus responder's byte is captured from MISO,
// so a single frame writes the OLED and reads the button state back.
// Bytes come in over a valid/ready stream; tx_last closes the frame.
//
// Ports:
//   clk_25mhz, resetn          clock, asynchronous active-low reset
//   tx_valid/tx_ready          byte handshake (ready in IDLE and WAIT)
//   tx_data/tx_dc/tx_last      byte, OLED D/C level, end-of-frame flag
//   rx_valid/rx_data           one-cycle pulse with the captured MISO byte
//   busy                       high whenever the FSM is not IDLE
//   spi_csn/spi_clk/spi_mosi/spi_dc/spi_miso   SPI pins
module spi_oled_btn_master #(
    parameter int C_clk_div = 4,
    parameter int C_bits    = 8
) (
    input  logic              clk_25mhz,
    input  logic              resetn,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic [C_bits-1:0] tx_data,
    input  logic              tx_dc,
    input  logic              tx_last,
    output logic              rx_valid,
    output logic [C_bits-1:0] rx_data,
    output logic              busy,
    output logic              spi_csn,
    output logic              spi_clk,
    output logic              spi_mosi,
    output logic              spi_dc,
    input  logic              spi_miso
);

    localparam int CW = (C_clk_div > 1) ? $clog2(C_clk_div) : 1;
    localparam int BW = $clog2(C_bits + 1);

    typedef enum logic [2:0] {
        IDLE, SETUP, LOW, HIGH, BYTE_END, WAIT, HOLD, GAP
    } state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [BW-1:0]     bit_cnt;
    logic [C_bits-1:0] tx_sh;
    logic [C_bits-1:0] rx_sh;
    logic              last_q;
    logic              phase_done;

    assign phase_done = (cnt == CW'(C_clk_div - 1));
    assign tx_ready   = (state == IDLE) || (state == WAIT);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk_25mhz or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= '0;
            tx_sh    <= '0;
            rx_sh    <= '0;
            last_q   <= 1'b0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            spi_csn  <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            spi_dc   <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE, WAIT: begin
                    cnt <= '0;
                    if (tx_valid) begin
                        // Latch the whole byte so later input changes are ignored.
                        tx_sh    <= tx_data;
                        spi_mosi <= tx_data[C_bits-1];
                        spi_dc   <= tx_dc;
                        last_q   <= tx_last;
                        bit_cnt  <= '0;
                        spi_csn  <= 1'b0;
                        state    <= SETUP;
                    end
                end
                SETUP, LOW: begin
                    if (phase_done) begin
                        // Rising edge: sample MISO as SCK goes high.
                        cnt     <= '0;
                        spi_clk <= 1'b1;
                        rx_sh   <= {rx_sh[C_bits-2:0], spi_miso};
                        bit_cnt <= bit_cnt + 1'b1;
                        state   <= HIGH;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HIGH: begin
                    if (phase_done) begin
                        cnt     <= '0;
                        spi_clk <= 1'b0;
                        if (bit_cnt == BW'(C_bits)) begin
                            rx_valid <= 1'b1;
                            rx_data  <= rx_sh;
                            state    <= BYTE_END;
                        end else begin
                            // Falling edge: advance MOSI to the next bit.
                            tx_sh    <= {tx_sh[C_bits-2:0], 1'b0};
                            spi_mosi <= tx_sh[C_bits-2];
                            state    <= LOW;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                BYTE_END: begin
                    cnt   <= '0;
                    state <= last_q ? HOLD : WAIT;
                end
                HOLD: begin
                    if (phase_done) begin
                        cnt     <= '0;
                        spi_csn <= 1'b1;
                        state   <= GAP;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                GAP: begin
                    // Guarantees minimum CSn-high time even with tx_valid held.
                    if (phase_done) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_oled_btn_master.sv
// Scoreboard bench for spi_oled_btn_master (C_clk_div=2, C_bits=8).
// Expected rx bytes are queued when stimulus is issued; a monitor pops and
// compares on every rx_valid pulse. Pin-level observers count SCK/CSn edges.
module tb_spi_oled_btn_master;

    logic       clk_25mhz = 1'b0;
    logic       resetn;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;
    logic       tx_dc;
    logic       tx_last;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       spi_csn, spi_clk, spi_mosi, spi_dc, spi_miso;

    int checks = 0;
    int errors = 0;

    int         miso_mode = 2;   // 0 loopback, 1 button responder, 2 constant 0
    logic [6:0] btn = '0;
    logic [7:0] btn_sr = '0;

    logic [7:0] exp_q[$];
    logic       mosi_q[$];
    logic       dc_at_edge;
    int sck_edges = 0, csn_rise = 0, csn_fall = 0, rx_cnt = 0;
    int csn_low_cycles = 0, hi_run = 0, min_gap = 1000;

    always #5 clk_25mhz = ~clk_25mhz;

    spi_oled_btn_master #(.C_clk_div(2), .C_bits(8)) dut (
        .clk_25mhz(clk_25mhz), .resetn(resetn),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
        .tx_dc(tx_dc), .tx_last(tx_last),
        .rx_valid(rx_valid), .rx_data(rx_data), .busy(busy),
        .spi_csn(spi_csn), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
        .spi_dc(spi_dc), .spi_miso(spi_miso)
    );

    // Button responder: {0,btn} rotated left on each SCK fall, MISO = bit0.
    always @(negedge spi_csn) btn_sr = {1'b0, btn};
    always @(negedge spi_clk) if (!spi_csn) btn_sr = {btn_sr[6:0], btn_sr[7]};
    assign spi_miso = (miso_mode == 0) ? spi_mosi :
                      (miso_mode == 1) ? btn_sr[0] : 1'b0;

    always @(posedge spi_clk) begin
        sck_edges++;
        mosi_q.push_back(spi_mosi);
        dc_at_edge = spi_dc;
    end
    always @(posedge spi_csn) csn_rise++;
    always @(negedge spi_csn) csn_fall++;

    always @(negedge clk_25mhz) begin
        if (spi_csn === 1'b0) begin
            csn_low_cycles++;
            if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
            hi_run = 0;
        end else begin
            hi_run++;
        end
    end

    // Scoreboard monitor
    always @(negedge clk_25mhz) begin
        if (resetn === 1'b1 && rx_valid === 1'b1) begin
            rx_cnt++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rx_unexpected: got rx_data=0x%0h, required no rx_valid", rx_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (rx_data !== e) begin
                    errors++;
                    $display("FAIL rx_data: got 0x%0h, required 0x%0h", rx_data, e);
                end
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk_range(input string name, input int act, input int lo, input int hi);
        checks++;
        if (act < lo || act > hi) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Offer a byte at a negedge, wait for acceptance on the next posedge.
    task automatic send(input logic [7:0] d, input logic dc, input logic last,
                        input bit hold, input bit push, input logic [7:0] exp);
        int n;
        @(negedge clk_25mhz);
        tx_valid = 1'b1; tx_data = d; tx_dc = dc; tx_last = last;
        n = 0;
        while (!tx_ready && n < 2000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 2000) chk("accept_timeout", 0, 1);
        if (push) exp_q.push_back(exp);
        @(posedge clk_25mhz);
        #1;
        if (!hold) tx_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk_25mhz);
        while (busy && n < 5000) begin
            @(negedge clk_25mhz);
            n++;
        end
        if (n >= 5000) chk("idle_timeout", 0, 1);
        repeat (3) @(negedge clk_25mhz);
    endtask

    function automatic logic [7:0] mosi_byte(input int start);
        logic [7:0] b;
        b = '0;
        for (int i = 0; i < 8; i++) b = {b[6:0], mosi_q[start + i]};
        return b;
    endfunction

    initial begin
        int n, e0, hi, clkhi;
        resetn = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_dc = 1'b0; tx_last = 1'b0;
        repeat (3) @(negedge clk_25mhz);
        chk("rst_csn", int'(spi_csn), 1);
        chk("rst_clk", int'(spi_clk), 0);
        chk("rst_mosi", int'(spi_mosi), 0);
        chk("rst_dc", int'(spi_dc), 0);
        chk("rst_rx_valid", int'(rx_valid), 0);
        chk("rst_rx_data", int'(rx_data), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_tx_ready", int'(tx_ready), 1);
        resetn = 1'b1;
        repeat (2) @(negedge clk_25mhz);

        // 1: single byte, MOSI pattern, D/C, CSn duration, one rx pulse
        miso_mode = 2;
        mosi_q.delete(); sck_edges = 0; csn_low_cycles = 0; rx_cnt = 0;
        send(8'hA5, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00);
        wait_idle();
        chk("t1_sck_edges", sck_edges, 8);
        if (mosi_q.size() == 8) chk("t1_mosi", int'(mosi_byte(0)), 8'hA5);
        else chk("t1_mosi_count", mosi_q.size(), 8);
        chk("t1_dc", int'(dc_at_edge), 1);
        chk_range("t1_csn_low", csn_low_cycles, 34, 36);
        chk("t1_rx_pulses", rx_cnt, 1);

        // 2: loopback burst, CSn held low across bytes
        miso_mode = 0;
        csn_rise = 0; csn_fall = 0; mosi_q.delete();
        send(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 8'h3C);
        send(8'hC3, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3);
        send(8'hFF, 1'b1, 1'b1, 1'b0, 1'b1, 8'hFF);
        wait_idle();
        chk("t2_csn_fall", csn_fall, 1);
        chk("t2_csn_rise", csn_rise, 1);
        chk("t2_q_empty", exp_q.size(), 0);

        // 3: button responder readback
        miso_mode = 1; btn = 7'b1010101;
        send(8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 8'hAA);
        wait_idle();
        chk("t3_q_empty", exp_q.size(), 0);

        // 4: reset after the 4th rising edge
        miso_mode = 2; sck_edges = 0; rx_cnt = 0;
        send(8'h55, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        n = 0;
        while (sck_edges < 4 && n < 500) begin
            @(negedge clk_25mhz);
            n++;
        end
        chk("t4_clk_high_before", int'(spi_clk), 1);
        resetn = 1'b0;
        #1;
        chk("t4_csn_async", int'(spi_csn), 1);
        chk("t4_clk_async", int'(spi_clk), 0);
        repeat (3) @(negedge clk_25mhz);
        resetn = 1'b1;
        repeat (40) @(negedge clk_25mhz);
        chk("t4_tx_ready", int'(tx_ready), 1);
        chk("t4_busy", int'(busy), 0);
        chk("t4_no_rx", rx_cnt, 0);
        chk("t4_edges_stopped", sck_edges, 4);

        // 5: tx_valid held across four one-byte frames
        miso_mode = 0; csn_fall = 0;
        send(8'h11, 1'b1, 1'b1, 1'b1, 1'b1, 8'h11);
        min_gap = 1000; hi_run = 0;
        send(8'h22, 1'b1, 1'b1, 1'b1, 1'b1, 8'h22);
        send(8'h33, 1'b1, 1'b1, 1'b1, 1'b1, 8'h33);
        send(8'h44, 1'b1, 1'b1, 1'b0, 1'b1, 8'h44);
        wait_idle();
        chk("t5_frames", csn_fall, 4);
        chk_range("t5_min_gap", min_gap, 2, 10);
        chk("t5_q_empty", exp_q.size(), 0);

        // 6: pause inside a frame, then resume
        miso_mode = 0; csn_fall = 0; csn_rise = 0; mosi_q.delete();
        send(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 8'h5A);
        n = 0;
        @(negedge clk_25mhz);
        while (!tx_ready && n < 500) begin
            @(negedge clk_25mhz);
            n++;
        end
        e0 = sck_edges; hi = 0; clkhi = 0;
        repeat (50) begin
            @(negedge clk_25mhz);
            if (spi_csn) hi++;
            if (spi_clk) clkhi++;
        end
        chk("t6_csn_low_wait", hi, 0);
        chk("t6_clk_low_wait", clkhi, 0);
        chk("t6_no_edges", sck_edges - e0, 0);
        send(8'hA6, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA6);
        wait_idle();
        chk("t6_one_frame", csn_fall * 16 + csn_rise, 17);
        if (mosi_q.size() == 16) chk("t6_mosi2", int'(mosi_byte(8)), 8'hA6);
        else chk("t6_mosi_count", mosi_q.size(), 16);
        chk("t6_q_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
